// File: rtl/fsk_tx_serializer.sv
// Byte-to-FSK serializer: pops bytes from an upstream FIFO and sends each as a
// 10-bit frame (start, 8 data LSB first, stop) using two square-wave tones.
module fsk_tx_serializer #(
  parameter int BIT_CYCLES = 1000,
  parameter int MARK_HALF  = 10,
  parameter int SPACE_HALF = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       empty,
  input  logic [7:0] r_data,
  output logic       rd,
  output logic       tx_out,
  output logic       tx_en,
  output logic       tone_sel,
  output logic       busy
);

  localparam int HALF_MAX = (MARK_HALF > SPACE_HALF) ? MARK_HALF : SPACE_HALF;
  localparam int BIT_W    = $clog2(BIT_CYCLES) + 1;
  localparam int HALF_W   = $clog2(HALF_MAX) + 1;

  localparam logic [BIT_W-1:0]  BIT_LAST   = BIT_W'(BIT_CYCLES - 1);
  localparam logic [HALF_W-1:0] MARK_LAST  = HALF_W'(MARK_HALF - 1);
  localparam logic [HALF_W-1:0] SPACE_LAST = HALF_W'(SPACE_HALF - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             state_q, state_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [2:0]         idx_q, idx_d;
  logic [7:0]         shift_q, shift_d;
  logic [HALF_W-1:0]  half_cnt_q, half_cnt_d;
  logic               tx_out_q, tx_out_d;

  logic               bit_end;
  logic               half_end;
  logic               fetch;
  logic [HALF_W-1:0]  half_last;

  always_comb begin
    busy     = (state_q != IDLE);
    tx_en    = busy;
    tx_out   = tx_out_q;
    tone_sel = 1'b0;
    case (state_q)
      DATA:    tone_sel = shift_q[idx_q];
      STOP:    tone_sel = 1'b1;
      default: tone_sel = 1'b0;
    endcase

    bit_end   = busy && (bit_cnt_q == BIT_LAST);
    half_last = tone_sel ? MARK_LAST : SPACE_LAST;
    half_end  = busy && (half_cnt_q == half_last);
    // Gating with reset keeps rd low while reset is held, even though the
    // state already reads IDLE.
    fetch = reset && enable && !empty &&
            ((state_q == IDLE) || ((state_q == STOP) && bit_end));
    rd    = fetch;

    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    half_cnt_d = half_cnt_q;
    tx_out_d   = tx_out_q;

    if (busy) begin
      bit_cnt_d  = bit_end ? '0 : bit_cnt_q + 1'b1;
      half_cnt_d = (bit_end || half_end) ? '0 : half_cnt_q + 1'b1;
      tx_out_d   = tx_out_q ^ half_end;
    end

    case (state_q)
      START: begin
        if (bit_end) begin
          state_d = DATA;
          idx_d   = 3'd0;
        end
      end
      DATA: begin
        if (bit_end) begin
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_d  = IDLE;
          tx_out_d = 1'b0;
        end
      end
      default: ;
    endcase

    // A new frame always begins from a clean tone phase at level 0.
    if (fetch) begin
      state_d    = START;
      shift_d    = r_data;
      bit_cnt_d  = '0;
      half_cnt_d = '0;
      idx_d      = 3'd0;
      tx_out_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      idx_q      <= 3'd0;
      shift_q    <= 8'h00;
      half_cnt_q <= '0;
      tx_out_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      half_cnt_q <= half_cnt_d;
      tx_out_q   <= tx_out_d;
    end
  end

endmodule

// File: tb/tb_fsk_tx_serializer.sv
// Bench for fsk_tx_serializer: frame-level reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_fsk_tx_serializer;

  localparam int BC = 40;
  localparam int MH = 2;
  localparam int SH = 4;

  logic       clk    = 1'b0;
  logic       reset  = 1'b0;
  logic       enable = 1'b0;
  logic       empty  = 1'b1;
  logic [7:0] r_data = 8'h00;
  logic       rd, tx_out, tx_en, tone_sel, busy;

  int total = 0;
  int bad   = 0;

  logic [7:0] fifo_mem [0:15];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  int         rd_cnt = 0;

  logic       tone_a [0:400];
  logic       out_a  [0:400];
  logic       en_a   [0:400];

  fsk_tx_serializer #(
    .BIT_CYCLES(BC),
    .MARK_HALF (MH),
    .SPACE_HALF(SH)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .empty   (empty),
    .r_data  (r_data),
    .rd      (rd),
    .tx_out  (tx_out),
    .tx_en   (tx_en),
    .tone_sel(tone_sel),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Upstream FIFO emulation: pops on rd, head word visible combinationally.
  always @(posedge clk) begin
    if (rd === 1'b1) begin
      rd_cnt++;
      if (rd_ptr != wr_ptr) rd_ptr++;
    end
    #1;
    empty  = (rd_ptr == wr_ptr);
    r_data = (rd_ptr == wr_ptr) ? 8'h00 : fifo_mem[rd_ptr];
  end

  // Reference model: a frame is 10 bits of BC cycles; tx_out is the parity of
  // the number of completed half-periods since the frame started.
  bit         m_busy = 1'b0;
  int         m_t    = 0;
  logic [7:0] m_byte = 8'h00;

  function automatic logic bitval(input int b, input logic [7:0] by);
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return by[b-1];
  endfunction

  function automatic int half_of(input logic v);
    return v ? MH : SH;
  endfunction

  always @(negedge clk) begin
    logic e_rd, e_out, e_en, e_tone;
    int   bi, k, tog;
    e_rd = 0; e_out = 0; e_en = 0; e_tone = 0;
    if (reset) begin
      if (m_busy) begin
        bi     = m_t / BC;
        k      = m_t % BC;
        e_tone = bitval(bi, m_byte);
        tog    = 0;
        for (int b = 0; b < bi; b++) tog += BC / half_of(bitval(b, m_byte));
        tog   += k / half_of(e_tone);
        e_out  = tog[0];
        e_en   = 1'b1;
      end
      e_rd = enable && !empty && (!m_busy || (m_t == 10*BC - 1));
    end
    check("rd",       rd,       e_rd);
    check("tx_out",   tx_out,   e_out);
    check("tx_en",    tx_en,    e_en);
    check("busy",     busy,     e_en);
    check("tone_sel", tone_sel, e_tone);
    if (!reset) begin
      m_busy = 1'b0;
    end else if (e_rd) begin
      m_busy = 1'b1;
      m_t    = 0;
      m_byte = r_data;
    end else if (m_busy) begin
      m_t++;
      if (m_t == 10*BC) m_busy = 1'b0;
    end
  end

  task automatic push(input logic [7:0] v);
    fifo_mem[wr_ptr] = v;
    wr_ptr++;
  endtask

  task automatic wait_rd(input int lim, input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (rd !== 1'b1 && n < lim) begin
      @(negedge clk);
      n++;
    end
    check(nm, rd, 1);
  endtask

  task automatic count_frame(input int lim, output int n);
    n = 0;
    @(negedge clk);
    while (tx_en === 1'b1 && n < lim) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    logic exp_tone [0:9];
    int   base, n, togs, any;
    exp_tone = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

    repeat (3) @(negedge clk);
    check("reset_tx_en", tx_en, 0);
    check("reset_busy", busy, 0);
    @(posedge clk); #2 reset = 1'b1;

    // Empty FIFO with enable toggling: nothing may happen.
    any = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #2 enable = (i % 3) != 0;
      @(negedge clk);
      if (rd === 1'b1 || tx_en === 1'b1 || tx_out === 1'b1) any = 1;
    end
    check("empty_idle_quiet", any, 0);
    check("empty_no_rd", rd_cnt, 0);

    // Single byte 8'hA5.
    @(posedge clk); #2 enable = 1'b1; push(8'hA5);
    base = rd_cnt;
    wait_rd(20, "a5_rd_seen");
    for (int t = 0; t <= 400; t++) begin
      @(negedge clk);
      tone_a[t] = tone_sel; out_a[t] = tx_out; en_a[t] = tx_en;
    end
    for (int b = 0; b < 10; b++) check("a5_tone_seq", tone_a[40*b+20], exp_tone[b]);
    togs = 0;
    for (int t = 0; t < 40; t++) if (out_a[t] != out_a[t+1]) togs++;
    check("space_toggles", togs, 10);
    togs = 0;
    for (int t = 40; t < 80; t++) if (out_a[t] != out_a[t+1]) togs++;
    check("mark_toggles", togs, 20);
    check("a5_first_out", out_a[0], 0);
    check("a5_en_first", en_a[0], 1);
    check("a5_en_last", en_a[399], 1);
    check("a5_idle_401", en_a[400], 0);
    check("a5_one_rd", rd_cnt - base, 1);

    // Back-to-back 8'h00 then 8'hFF.
    @(posedge clk); #2 push(8'h00); push(8'hFF);
    base = rd_cnt;
    wait_rd(20, "b2b_rd_seen");
    count_frame(2000, n);
    check("b2b_en_cycles", n, 800);
    check("b2b_two_rd", rd_cnt - base, 2);

    // enable dropped at cycle 100 of a frame; a byte remains queued.
    @(posedge clk); #2 push(8'h3C); push(8'h5A);
    base = rd_cnt;
    wait_rd(20, "en_drop_rd_seen");
    n = 0;
    @(negedge clk);
    while (tx_en === 1'b1 && n < 1000) begin
      n++;
      if (n == 100) begin
        @(posedge clk); #2 enable = 1'b0;
      end
      @(negedge clk);
    end
    check("en_drop_frame_len", n, 400);
    repeat (50) @(negedge clk);
    check("en_drop_no_more_rd", rd_cnt - base, 1);

    // Reset 150 cycles into a frame.
    @(posedge clk); #2 push(8'hC3); enable = 1'b1;
    wait_rd(20, "rst_rd_seen");
    repeat (150) @(negedge clk);
    @(posedge clk); #2 reset = 1'b0;
    #1;
    check("rst_tx_en", tx_en, 0);
    check("rst_tx_out", tx_out, 0);
    check("rst_busy", busy, 0);
    check("rst_tone", tone_sel, 0);
    check("rst_rd", rd, 0);
    repeat (5) @(negedge clk);
    @(posedge clk); #2 reset = 1'b1;
    @(negedge clk);
    check("rst_release_rd", rd, 1);
    count_frame(1000, n);
    check("rst_new_frame_len", n, 400);

    repeat (10) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fsk_tx_serializer.md
FSK_TX_SERIALIZER -- requirements
Module: fsk_tx_serializer

Interface
REQ-001 SHALL have parameter BIT_CYCLES, default 1000, the clock cycles per transmitted bit (legal range 2 or more).
REQ-002 SHALL have parameter MARK_HALF, default 10, the clock cycles per half-period of the mark (logic 1) tone (legal range 1 or more).
REQ-003 SHALL have parameter SPACE_HALF, default 20, the clock cycles per half-period of the space (logic 0) tone (legal range 1 or more).
REQ-004 clk  input  1  system clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 enable  input  1  permits fetching new bytes from the upstream FIFO.
REQ-007 empty  input  1  upstream FIFO empty flag.
REQ-008 r_data  input  8  upstream FIFO head word, valid when empty=0 and read combinationally.
REQ-009 rd  output  1  one-cycle pop strobe to the upstream FIFO.
REQ-010 tx_out  output  1  square-wave FSK drive to the transducer driver.
REQ-011 tx_en  output  1  transducer driver enable, high during a frame.
REQ-012 tone_sel  output  1  current bit value (1 = mark tone, 0 = space tone).
REQ-013 busy  output  1  high when the state is not IDLE.

Function
REQ-014 SHALL implement the states IDLE, START, DATA and STOP.
REQ-015 Frame format SHALL be: 1 start bit (0), then 8 data bits LSB first, then 1 stop bit (1), for 10*BIT_CYCLES cycles per frame.
REQ-016 In IDLE, when enable=1 and empty=0, rd SHALL be 1 for that cycle; the same edge SHALL capture r_data into the shift register and move to START.
REQ-017 rd SHALL never be asserted while empty=1, and SHALL never be high for two consecutive cycles.
REQ-018 Every bit SHALL last exactly BIT_CYCLES cycles, timed by a bit counter that counts 0..BIT_CYCLES-1 and restarts at each bit boundary.
REQ-019 State transitions:
- START to DATA after 1 bit.
- DATA to STOP after the 8th bit; a 3-bit index selects the bit.
- STOP to IDLE after 1 bit.
REQ-020 Back-to-back frames: in the last STOP cycle with enable=1 and empty=0, rd SHALL pulse, r_data SHALL be captured, and the next state SHALL be START directly, with no idle gap.
REQ-021 Tone generation: a half-period counter SHALL count 0..H-1, where H = MARK_HALF if tone_sel=1 else SPACE_HALF.
- tx_out SHALL toggle on the cycle the counter reaches H-1.
- The counter SHALL restart at 0 on every bit boundary.
- tx_out SHALL keep its level across bit boundaries (phase-continuous level).
REQ-022 tx_en and busy SHALL be 1 from the cycle after the rd pulse until the last STOP cycle inclusive.
REQ-023 In IDLE, tx_out, tx_en and tone_sel SHALL be 0; tx_out SHALL be forced to 0 on entering IDLE.
REQ-024 Every frame SHALL start with tx_out=0.
REQ-025 Deasserting enable mid-frame SHALL NOT abort the frame; only new fetches are blocked.
REQ-026 Changes on empty or r_data mid-frame SHALL have no effect on the frame in progress.
REQ-027 All counters SHALL be sized $clog2 of their terminal value plus 1 and SHALL NOT overflow at any legal parameter value.

Reset
REQ-028 reset=0 SHALL asynchronously force state IDLE, all counters 0, shift register 0, and rd=tx_out=tx_en=tone_sel=busy=0.
REQ-029 Reset mid-frame SHALL abort the frame immediately; the byte already popped is discarded and no rd is issued until reset is released.
REQ-030 After release, the first possible rd SHALL occur on the first rising edge where enable=1 and empty=0.

Verification (BIT_CYCLES=40, MARK_HALF=2, SPACE_HALF=4)
REQ-031 FIFO holds 8'hA5, enable=1 -> exactly one rd pulse; tone_sel sequence 0,1,0,1,0,0,1,0,1,1, each level held 40 cycles; then IDLE with tx_en=0 at cycle 401 after rd.
REQ-032 Tone period -> during a 0 bit tx_out toggles every 4 cycles (10 toggles per bit); during a 1 bit it toggles every 2 cycles (20 toggles per bit).
REQ-033 FIFO holds 8'h00 and 8'hFF -> second rd coincides with the last STOP cycle of frame 1; frame 2 starts the next cycle; 800 consecutive tx_en=1 cycles.
REQ-034 empty=1 throughout, enable toggling -> rd, tx_en and tx_out stay 0 indefinitely.
REQ-035 enable dropped at cycle 100 of a frame -> frame completes at 400 cycles; no further rd despite empty=0.
REQ-036 reset asserted at cycle 150 of a frame -> all outputs 0 immediately; after release with empty=0 and enable=1, a new frame starts with rd on the first edge.
